imm_extend_pipe: RTL and testbench

Pipelined, parametrised immediate-extension unit for the decode stage of the ARM 32-bit core. It adds the ARM rotated data-processing immediate with shifter carry-out, a halfword split-immediate mode and a configurable branch shift. Results leave through a two-stage valid/ready pipeline with backpressure and flush, so decode can be retimed without losing instructions.

---
 rtl/imm_extend_pipe.sv | 150 +++++++++++++++
 tb/tb_imm_extend_pipe.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: two-stage immediate-extension unit for the ARM decode stage.
// S1 captures the request and pre-decodes mode and rotation; S2 builds the
// extended immediate plus shifter carry and holds it under backpressure.
module imm_extend_pipe #(
   parameter int XLEN     = 32,
   parameter int BR_SHIFT = 2,
   parameter int TAG_W    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [23:0]      instr,
   input  logic [2:0]       imm_src,
   input  logic             carry_in,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  ext_imm,
   output logic             shifter_carry,
   output logic             illegal,
   output logic [TAG_W-1:0] out_tag
);

   typedef enum logic [2:0] {
      MODE_IMM8,
      MODE_IMM12,
      MODE_BRANCH,
      MODE_ROT,
      MODE_SPLIT,
      MODE_ILLEGAL
   } mode_e;

   // Pipeline state
   logic             s1_valid_q, s2_valid_q;
   logic [23:0]      s1_instr_q;
   mode_e            s1_mode_q, mode_d;
   logic [4:0]       s1_rot_q, rot_d;
   logic             s1_carry_q;
   logic [TAG_W-1:0] s1_tag_q;

   logic [XLEN-1:0]  ext_imm_q, ext_imm_d;
   logic             carry_q, carry_d;
   logic             illegal_q, illegal_d;
   logic [TAG_W-1:0] tag_q;

   logic             s1_load, s2_load;
   logic [31:0]      rot_src, rot_val;
   logic [XLEN-1:0]  br_sext;

   // Handshake: S2 accepts when empty or draining; S1 accepts when it empties into S2.
   always_comb begin
      s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
      in_ready = !flush && (!s1_valid_q || s2_load);
      s1_load  = in_valid && in_ready;
   end

   // Pre-decode of the mode select and rotate amount ahead of S1.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      mode_d = MODE_ILLEGAL;
      case (imm_src)
         3'b000:  mode_d = MODE_IMM8;
         3'b001:  mode_d = MODE_IMM12;
         3'b010:  mode_d = MODE_BRANCH;
         3'b011:  mode_d = MODE_ROT;
         3'b100:  mode_d = MODE_SPLIT;
         default: mode_d = MODE_ILLEGAL;
      endcase
      rot_d = {instr[11:8], 1'b0};
   end

   // Valid bits: flush empties both stages, otherwise track loads and drains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else if (flush) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         s1_valid_q <= s1_load || (s1_valid_q && !s2_load);
         s2_valid_q <= s2_load || (s2_valid_q && !out_ready);
      end
   end

   // S1 datapath: capture the accepted request with its pre-decoded fields.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: datapath registers are reset too, so outputs read zero straight out of reset.
         s1_instr_q <= '0;
         s1_mode_q  <= MODE_IMM8;
         s1_rot_q   <= '0;
         s1_carry_q <= 1'b0;
         s1_tag_q   <= '0;
      end else if (s1_load) begin
         s1_instr_q <= instr;
         s1_mode_q  <= mode_d;
         s1_rot_q   <= rot_d;
         s1_carry_q <= carry_in;
         s1_tag_q   <= in_tag;
      end
   end

   // S2 result: build the extended immediate and carry from the S1 fields.
   always_comb begin
      rot_src   = {24'd0, s1_instr_q[7:0]};
      // A shift by 32 yields zero, so rot = 0 passes the byte through unchanged.
      rot_val   = (rot_src >> s1_rot_q) | (rot_src << (6'd32 - {1'b0, s1_rot_q}));
      br_sext   = XLEN'($signed(s1_instr_q));
      ext_imm_d = '0;
      carry_d   = s1_carry_q;
      illegal_d = 1'b0;
      case (s1_mode_q)
         MODE_IMM8:   ext_imm_d = XLEN'(s1_instr_q[7:0]);
         MODE_IMM12:  ext_imm_d = XLEN'(s1_instr_q[11:0]);
         MODE_BRANCH: ext_imm_d = br_sext << BR_SHIFT;
         MODE_ROT: begin
            ext_imm_d = XLEN'(rot_val);
            if (s1_rot_q != 5'd0) carry_d = rot_val[31];
         end
         MODE_SPLIT:  ext_imm_d = XLEN'({s1_instr_q[11:8], s1_instr_q[3:0]});
         default:     illegal_d = 1'b1;
      endcase
   end

   // S2 output registers: load on advance, hold while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_imm_q <= '0;
         carry_q   <= 1'b0;
         illegal_q <= 1'b0;
         tag_q     <= '0;
      end else if (s2_load && !flush) begin
         ext_imm_q <= ext_imm_d;
         carry_q   <= carry_d;
         illegal_q <= illegal_d;
         tag_q     <= s1_tag_q;
      end
   end

   assign out_valid     = s2_valid_q;
   assign ext_imm       = ext_imm_q;
   assign shifter_carry = carry_q;
   assign illegal       = illegal_q;
   assign out_tag       = tag_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed test-plan vectors,
// backpressure, flush, mid-stream reset and a randomized scoreboard run.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready, carry_in;
   logic [23:0] instr;
   logic [2:0]  imm_src;
   logic [3:0]  in_tag;

   logic        in_ready, out_valid, shifter_carry, illegal;
   logic [31:0] ext_imm;
   logic [3:0]  out_tag;

   logic        b1_in_ready, b1_out_valid, b1_carry, b1_illegal;
   logic [31:0] b1_ext_imm;
   logic [3:0]  b1_out_tag;

   imm_extend_pipe #(.XLEN(32), .BR_SHIFT(2), .TAG_W(4)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .imm_src(imm_src), .carry_in(carry_in), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .ext_imm(ext_imm),
      .shifter_carry(shifter_carry), .illegal(illegal), .out_tag(out_tag)
   );

   imm_extend_pipe #(.XLEN(32), .BR_SHIFT(1), .TAG_W(4)) dut_b1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b1_in_ready),
      .instr(instr), .imm_src(imm_src), .carry_in(carry_in), .in_tag(in_tag),
      .out_valid(b1_out_valid), .out_ready(out_ready), .ext_imm(b1_ext_imm),
      .shifter_carry(b1_carry), .illegal(b1_illegal), .out_tag(b1_out_tag)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] imm;
      logic        c;
      logic        ill;
      logic [3:0]  tag;
   } exp_t;

   typedef struct packed {
      logic [23:0] ins;
      logic [2:0]  src;
      logic        cin;
      logic [31:0] imm;
      logic        c;
      logic        ill;
      logic [31:0] imm_b1;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   exp_t q[$];

   logic obs_acc, obs_cons, obs_ov, obs_ir, obs_b1_ov, obs_b1_ir;
   exp_t obs, obs_b1;

   // Reference model straight from the mode rules, using plain arithmetic.
   function automatic exp_t model(input logic [23:0] ins, input logic [2:0] src,
                                  input logic cin, input logic [3:0] tag, input int bsh);
      exp_t        e;
      longint      v;
      int          r;
      logic [31:0] val;
      e.imm = '0; e.c = cin; e.ill = 1'b0; e.tag = tag;
      case (src)
         3'd0: e.imm = 32'(ins[7:0]);
         3'd1: e.imm = 32'(ins[11:0]);
         3'd2: begin
            v = longint'(ins);
            if (v >= 64'sd8388608) v = v - 64'sd16777216;
            v = v * (64'sd1 <<< bsh);
            e.imm = v[31:0];
         end
         3'd3: begin
            r   = 2 * int'(ins[11:8]);
            val = 32'(ins[7:0]);
            for (int i = 0; i < r; i++) val = {val[0], val[31:1]};
            e.imm = val;
            if (r != 0) e.c = val[31];
         end
         3'd4: e.imm = 32'(ins[11:8]) * 16 + 32'(ins[3:0]);
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // One clock: drive inputs, observe handshake and outputs, advance past the edge.
   task automatic cycle(input logic v, input logic [23:0] ins, input logic [2:0] src,
                        input logic cin, input logic [3:0] tag, input logic ordy, input logic fl);
      in_valid = v; instr = ins; imm_src = src; carry_in = cin; in_tag = tag;
      out_ready = ordy; flush = fl;
      #1;
      obs_acc   = in_valid && in_ready;
      obs_cons  = out_valid && out_ready;
      obs_ov    = out_valid;
      obs_ir    = in_ready;
      obs       = '{imm: ext_imm, c: shifter_carry, ill: illegal, tag: out_tag};
      obs_b1_ov = b1_out_valid;
      obs_b1_ir = b1_in_ready;
      obs_b1    = '{imm: b1_ext_imm, c: b1_carry, ill: b1_illegal, tag: b1_out_tag};
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      carry_in = 1'b0; instr = '0; imm_src = '0; in_tag = '0;
      #2;
      checks++;
      if ({out_valid, ext_imm, shifter_carry, illegal, out_tag} !== 39'd0) begin
         errors++;
         $display("FAIL reset_outputs got ov=%b imm=%h c=%b ill=%b tag=%h want all zero",
                  out_valid, ext_imm, shifter_carry, illegal, out_tag);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || b1_in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b/%b want 1/1", in_ready, b1_in_ready);
      end
   endtask

   task automatic test_directed();
      vec_t vecs[9];
      vecs[0] = '{24'h0004FF, 3'd3, 1'b0, 32'hFF000000, 1'b1, 1'b0, 32'hFF000000};
      vecs[1] = '{24'h000012, 3'd3, 1'b1, 32'h00000012, 1'b1, 1'b0, 32'h00000012};
      vecs[2] = '{24'h000F01, 3'd3, 1'b1, 32'h00000004, 1'b0, 1'b0, 32'h00000004};
      vecs[3] = '{24'hFFFFFE, 3'd2, 1'b1, 32'hFFFFFFF8, 1'b1, 1'b0, 32'hFFFFFFFC};
      vecs[4] = '{24'h000010, 3'd2, 1'b0, 32'h00000040, 1'b0, 1'b0, 32'h00000020};
      vecs[5] = '{24'hABCDEF, 3'd0, 1'b1, 32'h000000EF, 1'b1, 1'b0, 32'h000000EF};
      vecs[6] = '{24'hABCDEF, 3'd1, 1'b0, 32'h00000DEF, 1'b0, 1'b0, 32'h00000DEF};
      vecs[7] = '{24'hABCDEF, 3'd4, 1'b1, 32'h000000DF, 1'b1, 1'b0, 32'h000000DF};
      vecs[8] = '{24'hABCDEF, 3'd6, 1'b1, 32'h00000000, 1'b1, 1'b1, 32'h00000000};
      for (int i = 0; i < 9; i++) begin
         cycle(1'b1, vecs[i].ins, vecs[i].src, vecs[i].cin, 4'(i), 1'b1, 1'b0);
         checks++;
         if (obs_acc !== 1'b1) begin
            errors++;
            $display("FAIL dir_accept[%0d] got %b want 1", i, obs_acc);
         end
         cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
         checks++;
         if (obs_ov !== 1'b0) begin
            errors++;
            $display("FAIL dir_latency_early[%0d] out_valid got %b want 0", i, obs_ov);
         end
         cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
         checks++;
         if (obs_ov !== 1'b1 || obs.imm !== vecs[i].imm || obs.c !== vecs[i].c ||
             obs.ill !== vecs[i].ill || obs.tag !== 4'(i)) begin
            errors++;
            $display("FAIL dir_result[%0d] got ov=%b imm=%h c=%b ill=%b tag=%h want ov=1 imm=%h c=%b ill=%b tag=%h",
                     i, obs_ov, obs.imm, obs.c, obs.ill, obs.tag, vecs[i].imm, vecs[i].c, vecs[i].ill, 4'(i));
         end
         checks++;
         if (obs_b1_ov !== 1'b1 || obs_b1.imm !== vecs[i].imm_b1 || obs_b1.c !== vecs[i].c ||
             obs_b1.ill !== vecs[i].ill || obs_b1.tag !== 4'(i)) begin
            errors++;
            $display("FAIL dir_br1[%0d] got ov=%b imm=%h c=%b ill=%b want ov=1 imm=%h c=%b ill=%b",
                     i, obs_b1_ov, obs_b1.imm, obs_b1.c, obs_b1.ill, vecs[i].imm_b1, vecs[i].c, vecs[i].ill);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [3:0] tag      = 4'd1;
      int         accepts  = 0;
      int         next_exp = 1;
      for (int cyc = 0; cyc < 4; cyc++) begin
         cycle(1'b1, {16'h0, 4'h3, tag}, 3'd0, 1'b0, tag, 1'b0, 1'b0);
         checks++;
         if (obs_acc !== (cyc < 2)) begin
            errors++;
            $display("FAIL bp_accept[%0d] got %b want %b", cyc, obs_acc, (cyc < 2));
         end
         if (obs_acc) begin tag++; accepts++; end
         if (cyc >= 2) begin
            checks++;
            if (obs_ov !== 1'b1 || obs.tag !== 4'd1 || obs.imm !== 32'h31) begin
               errors++;
               $display("FAIL bp_hold[%0d] got ov=%b tag=%h imm=%h want ov=1 tag=1 imm=31",
                        cyc, obs_ov, obs.tag, obs.imm);
            end
         end
      end
      checks++;
      if (accepts != 2) begin
         errors++;
         $display("FAIL bp_accept_count got %0d want 2", accepts);
      end
      for (int cyc = 0; cyc < 30 && next_exp <= 5; cyc++) begin
         cycle(tag <= 4'd5, {16'h0, 4'h3, tag}, 3'd0, 1'b0, tag, 1'b1, 1'b0);
         if (obs_acc) tag++;
         if (obs_cons) begin
            checks++;
            if (obs.tag !== 4'(next_exp) || obs.imm !== 32'h30 + 32'(next_exp)) begin
               errors++;
               $display("FAIL bp_order got tag=%h imm=%h want tag=%h imm=%h",
                        obs.tag, obs.imm, 4'(next_exp), 32'h30 + 32'(next_exp));
            end
            next_exp++;
         end
      end
      checks++;
      if (next_exp != 6) begin
         errors++;
         $display("FAIL bp_drain got %0d results want 5", next_exp - 1);
      end
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs_ov !== 1'b0) begin
         errors++;
         $display("FAIL bp_no_dup out_valid got %b want 0", obs_ov);
      end
   endtask

   task automatic test_flush();
      cycle(1'b1, 24'h000011, 3'd0, 1'b0, 4'h1, 1'b0, 1'b0);
      cycle(1'b1, 24'h000022, 3'd0, 1'b0, 4'h2, 1'b0, 1'b0);
      cycle(1'b1, 24'h000033, 3'd0, 1'b0, 4'h3, 1'b0, 1'b1);
      checks++;
      if (obs_acc !== 1'b0 || obs_ir !== 1'b0) begin
         errors++;
         $display("FAIL flush_in_ready got %b want 0", obs_ir);
      end
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0);
      checks++;
      if (obs_ov !== 1'b0 || obs_ir !== 1'b1) begin
         errors++;
         $display("FAIL flush_empty got ov=%b ir=%b want ov=0 ir=1", obs_ov, obs_ir);
      end
      cycle(1'b1, 24'h000123, 3'd1, 1'b0, 4'h7, 1'b1, 1'b0);
      checks++;
      if (obs_acc !== 1'b1) begin
         errors++;
         $display("FAIL flush_restart_accept got %b want 1", obs_acc);
      end
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs_ov !== 1'b0) begin
         errors++;
         $display("FAIL flush_restart_early got ov=%b want 0", obs_ov);
      end
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs_ov !== 1'b1 || obs.imm !== 32'h123 || obs.tag !== 4'h7) begin
         errors++;
         $display("FAIL flush_restart_result got ov=%b imm=%h tag=%h want ov=1 imm=123 tag=7",
                  obs_ov, obs.imm, obs.tag);
      end
      // Flush while a result is being consumed.
      cycle(1'b1, 24'h000044, 3'd0, 1'b0, 4'h3, 1'b0, 1'b0);
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b0, 1'b0);
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b1);
      checks++;
      if (obs_cons !== 1'b1 || obs.tag !== 4'h3 || obs.imm !== 32'h44) begin
         errors++;
         $display("FAIL flush_consume got cons=%b tag=%h imm=%h want cons=1 tag=3 imm=44",
                  obs_cons, obs.tag, obs.imm);
      end
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs_ov !== 1'b0) begin
         errors++;
         $display("FAIL flush_consume_empty got ov=%b want 0", obs_ov);
      end
   endtask

   task automatic test_reset_midstream();
      cycle(1'b1, 24'h0004FF, 3'd3, 1'b0, 4'hA, 1'b0, 1'b0);
      cycle(1'b1, 24'h000012, 3'd0, 1'b0, 4'hB, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || ext_imm !== 32'hFF000000 || shifter_carry !== 1'b1 || out_tag !== 4'hA) begin
         errors++;
         $display("FAIL rst_mid_pre got ov=%b imm=%h c=%b tag=%h want ov=1 imm=ff000000 c=1 tag=a",
                  out_valid, ext_imm, shifter_carry, out_tag);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({out_valid, ext_imm, shifter_carry, illegal, out_tag} !== 39'd0) begin
         errors++;
         $display("FAIL rst_mid_async got ov=%b imm=%h c=%b ill=%b tag=%h want all zero",
                  out_valid, ext_imm, shifter_carry, illegal, out_tag);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
      end
      cycle(1'b1, 24'hABCDEF, 3'd4, 1'b0, 4'h9, 1'b1, 1'b0);
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs_ov !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_early got ov=%b want 0", obs_ov);
      end
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs_ov !== 1'b1 || obs.imm !== 32'hDF || obs.tag !== 4'h9 || obs.ill !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_restart got ov=%b imm=%h tag=%h ill=%b want ov=1 imm=df tag=9 ill=0",
                  obs_ov, obs.imm, obs.tag, obs.ill);
      end
   endtask

   // Randomized traffic against a queue-based scoreboard, with occasional flushes.
   task automatic test_random();
      logic [23:0] ins;
      logic [2:0]  src;
      logic        cin, v, ordy, fl;
      logic [3:0]  tag;
      q.delete();
      for (int n = 0; n < 400; n++) begin
         ins  = 24'($urandom);
         src  = 3'($urandom_range(0, 7));
         cin  = 1'($urandom);
         tag  = 4'($urandom);
         v    = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 6);
         fl   = ($urandom_range(0, 19) == 0);
         cycle(v, ins, src, cin, tag, ordy, fl);
         if (obs_ov) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rnd_spurious got ov=1 tag=%h want ov=0", obs.tag);
            end else if (obs !== q[0]) begin
               errors++;
               $display("FAIL rnd_result got imm=%h c=%b ill=%b tag=%h want imm=%h c=%b ill=%b tag=%h",
                        obs.imm, obs.c, obs.ill, obs.tag, q[0].imm, q[0].c, q[0].ill, q[0].tag);
            end
         end
         if (obs_cons && q.size() > 0) void'(q.pop_front());
         if (fl) begin
            checks++;
            if (obs_ir !== 1'b0) begin
               errors++;
               $display("FAIL rnd_flush_ready got %b want 0", obs_ir);
            end
            q.delete();
         end else if (obs_acc) begin
            q.push_back(model(ins, src, cin, tag, 2));
         end
      end
      for (int n = 0; n < 20 && q.size() > 0; n++) begin
         cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
         if (obs_ov) begin
            checks++;
            if (obs !== q[0]) begin
               errors++;
               $display("FAIL rnd_drain got imm=%h tag=%h want imm=%h tag=%h",
                        obs.imm, obs.tag, q[0].imm, q[0].tag);
            end
            void'(q.pop_front());
         end
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL rnd_lost got %0d outstanding want 0", q.size());
      end
      cycle(1'b0, 24'h0, 3'd0, 1'b0, 4'h0, 1'b1, 1'b0);
      checks++;
      if (obs_ov !== 1'b0) begin
         errors++;
         $display("FAIL rnd_extra got ov=%b want 0", obs_ov);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_flush();
      test_random();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
